rx_peak_finder: RTL and testbench

//  Parametrised correlation peak detector; sits after rx_correlator in the rx chain.

---
 rtl/rx_peak_finder.sv | 239 +++++++++++++++++++++++
 tb/tb_rx_peak_finder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : rx_peak_finder
// Summary  : |x| per correlation channel, max-select, then a threshold/hold
//            tracker that reports one peak (id, magnitude, timestamp) per burst.
// Revision : 1.0
// ============================================================================
module rx_peak_finder #(
  parameter int NUM_SEQ   = 16,
  parameter int CORR_W    = 41,
  parameter int TS_W      = 32,
  parameter int HOLD_LEN  = 64,
  parameter int BLANK_LEN = 256
) (
  input  logic                       crx_clk,
  input  logic                       rrx_rst_n,
  input  logic                       erx_en,
  input  logic                       inew_corr_trig,
  input  logic [NUM_SEQ*CORR_W-1:0]  icorr_flat,
  input  logic [CORR_W-2:0]          ithreshold,
  output logic                       opeak_valid,
  output logic [$clog2(NUM_SEQ)-1:0] opeak_seq_id,
  output logic [CORR_W-2:0]          opeak_value,
  output logic [TS_W-1:0]            opeak_timestamp,
  output logic                       obusy
);

  localparam int ID_W    = $clog2(NUM_SEQ);
  localparam int MAG_W   = CORR_W - 1;
  localparam int HOLD_W  = $clog2(HOLD_LEN + 1);
  localparam int BLANK_W = (BLANK_LEN > 0) ? $clog2(BLANK_LEN + 1) : 1;
  localparam logic [HOLD_W-1:0]  C_HOLD  = HOLD_W'(HOLD_LEN);
  localparam logic [BLANK_W-1:0] C_BLANK = BLANK_W'(BLANK_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_REPORT = 2'd2,
    S_BLANK  = 2'd3
  } state_t;

  logic [MAG_W-1:0] w_abs [NUM_SEQ];

  generate
    for (genvar g = 0; g < NUM_SEQ; g++) begin : g_abs
      logic [CORR_W-1:0] w_raw;
      logic [CORR_W-1:0] w_neg;
      assign w_raw = icorr_flat[g*CORR_W +: CORR_W];
      assign w_neg = ~w_raw + CORR_W'(1);
      // Only the most negative input still has its sign bit set after negation.
      assign w_abs[g] = !w_raw[CORR_W-1] ? w_raw[MAG_W-1:0] :
                        w_neg[CORR_W-1]  ? {MAG_W{1'b1}}    : w_neg[MAG_W-1:0];
    end
  endgenerate

  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_s1_ts;
  logic [TS_W-1:0]  r_s2_ts;
  logic             r_s1_valid;
  logic             r_s2_valid;
  logic [MAG_W-1:0] r_s1_mag [NUM_SEQ];
  logic [MAG_W-1:0] r_s2_max;
  logic [ID_W-1:0]  r_s2_id;
  logic [MAG_W-1:0] w_max;
  logic [ID_W-1:0]  w_max_id;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_max    = r_s1_mag[0];
    w_max_id = '0;
    for (int k = 1; k < NUM_SEQ; k++) begin
      if (r_s1_mag[k] > w_max) begin
        w_max    = r_s1_mag[k];
        w_max_id = ID_W'(k);
      end
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_ts       <= '0;
      r_s1_ts    <= '0;
      r_s2_ts    <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_max   <= '0;
      r_s2_id    <= '0;
      for (int k = 0; k < NUM_SEQ; k++) r_s1_mag[k] <= '0;
    end else if (!erx_en) begin
      r_ts       <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s1_valid <= inew_corr_trig;
      r_s2_valid <= r_s1_valid;
      if (inew_corr_trig) begin
        r_ts     <= r_ts + TS_W'(1);
        r_s1_ts  <= r_ts;
        r_s1_mag <= w_abs;
      end
      if (r_s1_valid) begin
        r_s2_max <= w_max;
        r_s2_id  <= w_max_id;
        r_s2_ts  <= r_s1_ts;
      end
    end
  end

  state_t             r_state;
  state_t             w_state_nx;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_nx;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic [BLANK_W-1:0] r_blank_cnt;
  logic [BLANK_W-1:0] w_blank_nx;
  logic [BLANK_W-1:0] w_blank_inc;
  logic               w_store;
  logic               w_report;
  logic               w_above;
  logic [MAG_W-1:0]   r_st_val;
  logic [ID_W-1:0]    r_st_id;
  logic [TS_W-1:0]    r_st_ts;
  logic               r_peak_valid;
  logic [ID_W-1:0]    r_peak_id;
  logic [MAG_W-1:0]   r_peak_val;
  logic [TS_W-1:0]    r_peak_ts;

  assign w_above     = (r_s2_max >= ithreshold);
  assign w_hold_inc  = r_hold_cnt + HOLD_W'(1);
  assign w_blank_inc = r_blank_cnt + BLANK_W'(1);

  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold_cnt;
    w_blank_nx = r_blank_cnt;
    w_store    = 1'b0;
    w_report   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_s2_valid && w_above) begin
          w_store    = 1'b1;
          w_hold_nx  = '0;
          w_state_nx = S_TRACK;
        end
      end
      S_TRACK: begin
        if (r_s2_valid) begin
          if (r_s2_max > r_st_val) begin
            w_store   = 1'b1;
            w_hold_nx = '0;
          end else if (w_hold_inc == C_HOLD) begin
            w_report   = 1'b1;
            w_hold_nx  = '0;
            w_state_nx = S_REPORT;
          end else begin
            w_hold_nx = w_hold_inc;
          end
        end
      end
      S_REPORT: begin
        w_blank_nx = '0;
        // A sample landing on the report cycle is consumed as the next state would.
        if (BLANK_LEN == 0) begin
          w_state_nx = S_IDLE;
          if (r_s2_valid && w_above) begin
            w_store    = 1'b1;
            w_hold_nx  = '0;
            w_state_nx = S_TRACK;
          end
        end else if (r_s2_valid && (C_BLANK == BLANK_W'(1))) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_BLANK;
          if (r_s2_valid) w_blank_nx = BLANK_W'(1);
        end
      end
      S_BLANK: begin
        if (r_s2_valid) begin
          if (w_blank_inc == C_BLANK) begin
            w_blank_nx = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_blank_nx = w_blank_inc;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_blank_cnt  <= '0;
      r_st_val     <= '0;
      r_st_id      <= '0;
      r_st_ts      <= '0;
      r_peak_valid <= 1'b0;
      r_peak_id    <= '0;
      r_peak_val   <= '0;
      r_peak_ts    <= '0;
    end else if (!erx_en) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_blank_cnt  <= '0;
      r_st_val     <= '0;
      r_st_id      <= '0;
      r_st_ts      <= '0;
      r_peak_valid <= 1'b0;
      r_peak_id    <= '0;
      r_peak_val   <= '0;
      r_peak_ts    <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_hold_cnt   <= w_hold_nx;
      r_blank_cnt  <= w_blank_nx;
      r_peak_valid <= w_report;
      if (w_store) begin
        r_st_val <= r_s2_max;
        r_st_id  <= r_s2_id;
        r_st_ts  <= r_s2_ts;
      end
      if (w_report) begin
        r_peak_id  <= r_st_id;
        r_peak_val <= r_st_val;
        r_peak_ts  <= r_st_ts;
      end
    end
  end

  assign opeak_valid     = r_peak_valid;
  assign opeak_seq_id    = r_peak_id;
  assign opeak_value     = r_peak_val;
  assign opeak_timestamp = r_peak_ts;
  assign obusy           = (r_state == S_TRACK) || (r_state == S_BLANK);

endmodule
`default_nettype wire

// File: tb/tb_rx_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_peak_finder
// Summary  : Two parameterisations of rx_peak_finder on shared stimulus, checked
//            against a per-sample behavioural model through report scoreboards.
// Revision : 1.0
// ============================================================================
module tb_rx_peak_finder;

  localparam longint MNEG = -64'sh100_0000_0000;
  localparam longint MAXM = 64'sh0FF_FFFF_FFFF;

  typedef struct {
    int     id;
    longint val;
    longint ts;
    longint cyc;
  } rep_t;

  logic             clk = 1'b0;
  logic             rst_n, en, trig;
  logic [16*41-1:0] flat;
  logic [39:0]      thr;
  logic             a_valid, a_busy, b_valid, b_busy;
  logic [3:0]       a_id, a_ts, b_id;
  logic [39:0]      a_value, b_value;
  logic [31:0]      b_ts;

  rx_peak_finder #(.NUM_SEQ(16), .CORR_W(41), .TS_W(4), .HOLD_LEN(4), .BLANK_LEN(8)) u_dut_a (
    .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .inew_corr_trig(trig),
    .icorr_flat(flat), .ithreshold(thr), .opeak_valid(a_valid), .opeak_seq_id(a_id),
    .opeak_value(a_value), .opeak_timestamp(a_ts), .obusy(a_busy));

  rx_peak_finder #(.NUM_SEQ(16), .CORR_W(41), .TS_W(32), .HOLD_LEN(2), .BLANK_LEN(0)) u_dut_b (
    .crx_clk(clk), .rrx_rst_n(rst_n), .erx_en(en), .inew_corr_trig(trig),
    .icorr_flat(flat), .ithreshold(thr), .opeak_valid(b_valid), .opeak_seq_id(b_id),
    .opeak_value(b_value), .opeak_timestamp(b_ts), .obusy(b_busy));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: operates on the sample sequence, independent of cycle timing.
  int     HOLD_P [2] = '{4, 2};
  int     BLANK_P[2] = '{8, 0};
  int     TSW_P  [2] = '{4, 32};
  int     m_st   [2];              // 0 idle, 1 tracking, 2 blanking
  longint m_val  [2];
  int     m_id   [2];
  longint m_ts   [2];
  int     m_hold [2];
  int     m_blank[2];
  longint m_cnt;
  rep_t   qa[$];
  rep_t   qb[$];
  longint smp[16];

  function automatic longint mag(input longint v);
    if (v == MNEG) return MAXM;
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_hold[k] = 0; m_blank[k] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input longint dc);
    longint bm, ts;
    int     bi;
    rep_t   r;
    bm = -1; bi = 0;
    for (int c = 0; c < 16; c++) begin
      if (mag(smp[c]) > bm) begin
        bm = mag(smp[c]);
        bi = c;
      end
    end
    for (int k = 0; k < 2; k++) begin
      ts = m_cnt & ((longint'(1) << TSW_P[k]) - 1);
      if (m_st[k] == 0) begin
        if (bm >= longint'(thr)) begin
          m_st[k] = 1; m_val[k] = bm; m_id[k] = bi; m_ts[k] = ts; m_hold[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (bm > m_val[k]) begin
          m_val[k] = bm; m_id[k] = bi; m_ts[k] = ts; m_hold[k] = 0;
        end else begin
          m_hold[k]++;
          if (m_hold[k] == HOLD_P[k]) begin
            r.id = m_id[k]; r.val = m_val[k]; r.ts = m_ts[k]; r.cyc = dc + 3;
            if (k == 0) qa.push_back(r);
            else        qb.push_back(r);
            m_st[k]    = (BLANK_P[k] > 0) ? 2 : 0;
            m_blank[k] = 0;
          end
        end
      end else begin
        m_blank[k]++;
        if (m_blank[k] == BLANK_P[k]) m_st[k] = 0;
      end
    end
    m_cnt++;
  endtask

  logic prev_v[2] = '{1'b0, 1'b0};

  task automatic mon(input int k, input logic v, input int id, input longint val, input longint ts);
    rep_t  e;
    string p;
    p = (k == 0) ? "A" : "B";
    if (v) begin
      chk({p, "_no_double_pulse"}, longint'(prev_v[k]), 0);
      if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
        chk({p, "_unexpected_report"}, 1, 0);
      end else begin
        if (k == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        chk({p, "_rep_id"}, id, e.id);
        chk({p, "_rep_value"}, val, e.val);
        chk({p, "_rep_ts"}, ts, e.ts);
        chk({p, "_rep_cycle"}, cyc, e.cyc);
      end
    end
    prev_v[k] = v;
  endtask

  always @(negedge clk) begin
    if (!rst_n || !en) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      mon(0, a_valid, int'(a_id), longint'(a_value), longint'(a_ts));
      mon(1, b_valid, int'(b_id), longint'(b_value), longint'(b_ts));
    end
  end

  task automatic clr();
    for (int c = 0; c < 16; c++) smp[c] = 0;
  endtask

  // Called just after a negedge; the strobe is seen by exactly one posedge.
  task automatic send(input int gap);
    for (int c = 0; c < 16; c++) flat[c*41 +: 41] = smp[c][40:0];
    trig = 1'b1;
    model_step(cyc);
    @(negedge clk);
    trig = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic quiet(input int n);
    clr();
    repeat (n) send(0);
  endtask

  task automatic one(input int ch, input longint v);
    clr();
    smp[ch] = v;
    send(0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     ch;
    longint v;
    longint idx600;
    bit     found;

    rst_n = 1'b0; en = 1'b1; trig = 1'b0; flat = '0; thr = 40'd100;
    model_clear();
    clr();
    idle(3);
    chk("rst_a_valid", longint'(a_valid), 0);
    chk("rst_a_id", longint'(a_id), 0);
    chk("rst_a_value", longint'(a_value), 0);
    chk("rst_a_ts", longint'(a_ts), 0);
    chk("rst_a_busy", longint'(a_busy), 0);
    chk("rst_b_value", longint'(b_value), 0);
    chk("rst_b_busy", longint'(b_busy), 0);
    rst_n = 1'b1;
    idle(1);

    // Single burst on channel 5
    one(5, 50); one(5, 200); one(5, -300); one(5, 250);
    quiet(3);
    idle(6);
    chk("t1_a_id", longint'(a_id), 5);
    chk("t1_a_value", longint'(a_value), 300);
    chk("t1_a_ts", longint'(a_ts), 2);

    // Tie between channels 3 and 9, then the most negative input
    quiet(8);
    clr(); smp[3] = 500; smp[9] = -500; send(0);
    quiet(4);
    idle(6);
    chk("tie_a_id", longint'(a_id), 3);
    chk("tie_a_value", longint'(a_value), 500);
    quiet(8);
    one(4, MNEG);
    quiet(4);
    idle(6);
    chk("sat_a_id", longint'(a_id), 4);
    chk("sat_a_value", longint'(a_value), MAXM);

    // Blanking: burst 3 samples after a report is ignored, 10 samples after is taken
    quiet(2);
    one(7, 1000);
    quiet(6);
    chk("blank_ignored_a_value", longint'(a_value), MAXM);
    one(7, 1000);
    quiet(4);
    idle(6);
    chk("after_blank_a_value", longint'(a_value), 1000);

    // Climbing peak restarts the hold counter
    quiet(8);
    one(0, 200); one(0, 150); one(0, 400); one(0, 150);
    idx600 = m_cnt;
    one(0, 600);
    quiet(4);
    idle(6);
    chk("climb_b_value", longint'(b_value), 600);
    chk("climb_b_ts", longint'(b_ts), idx600);
    chk("climb_a_value", longint'(a_value), 600);

    // Enable drop mid-track discards the candidate
    quiet(8);
    one(2, 2000);
    quiet(1);
    idle(4);
    chk("track_a_busy", longint'(a_busy), 1);
    chk("track_b_busy", longint'(b_busy), 1);
    en = 1'b0;
    model_clear();
    @(negedge clk);
    en = 1'b1;
    chk("clr_a_value", longint'(a_value), 0);
    chk("clr_a_id", longint'(a_id), 0);
    chk("clr_a_ts", longint'(a_ts), 0);
    chk("clr_a_busy", longint'(a_busy), 0);
    chk("clr_b_value", longint'(b_value), 0);
    chk("clr_b_busy", longint'(b_busy), 0);
    idle(6);
    quiet(3);
    one(1, 700);
    quiet(4);
    idle(6);
    chk("ts_restart_a_ts", longint'(a_ts), 3);
    chk("ts_restart_b_ts", longint'(b_ts), 3);

    // Asynchronous reset landing in the middle of a report pulse
    quiet(8);
    one(6, 900);
    quiet(4);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(posedge clk);
      #2;
      if (a_valid) found = 1'b1;
    end
    chk("async_pulse_seen", longint'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("async_a_valid", longint'(a_valid), 0);
    chk("async_a_value", longint'(a_value), 0);
    chk("async_a_id", longint'(a_id), 0);
    chk("async_b_value", longint'(b_value), 0);
    qa.delete();
    qb.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Narrow timestamp wraps
    quiet(20);
    one(11, -800);
    quiet(4);
    idle(6);
    chk("wrap_a_ts", longint'(a_ts), 4);
    chk("wrap_a_id", longint'(a_id), 11);
    chk("wrap_b_ts", longint'(b_ts), 20);

    // Randomised traffic: random threshold, then zero threshold
    for (int ph = 0; ph < 2; ph++) begin
      idle(6);
      thr = (ph == 0) ? 40'($urandom_range(500, 3000)) : 40'd0;
      for (int n = 0; n < ((ph == 0) ? 300 : 40); n++) begin
        for (int c = 0; c < 16; c++) smp[c] = longint'($urandom_range(0, 800)) - 400;
        if ($urandom_range(0, 5) == 0) begin
          ch = int'($urandom_range(0, 15));
          v  = longint'($urandom_range(0, 5000));
          if ($urandom_range(0, 1) == 1) v = -v;
          smp[ch] = v;
          if ($urandom_range(0, 3) == 0) smp[(ch + 5) % 16] = -v;
          if ($urandom_range(0, 49) == 0) smp[ch] = MNEG;
        end
        send(int'($urandom_range(0, 2)));
      end
    end

    idle(20);
    chk("a_pending_reports", longint'(qa.size()), 0);
    chk("b_pending_reports", longint'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
